// File: rtl/vedic_mul_arbiter.sv
// ---------------------------------------------------------------------------
// vedic_mul_arbiter
//
// Shares one pipelined 4x4 multiplier between NREQ requesters. Operand pairs
// arrive on per-requester valid/ready channels. A round-robin arbiter picks at
// most one of them per cycle and issues it to the multiplier. The requester
// index (tag) of every issued operation is queued. When the multiplier
// reports completion, the tag and the product are paired again and placed in
// a response FIFO.
//
// The multiplier cannot be stalled. A credit counter therefore limits
// in-flight operations plus buffered responses to DEPTH. This ensures that
// every completion finds room in the response FIFO.
//
// Ports
//   clk         rising-edge clock for all logic
//   reset       asynchronous, active-low reset
//   req_valid   [NREQ]     requester i offers an operand pair
//   req_ready   [NREQ]     one-hot grant (combinational)
//   req_a/req_b [4*NREQ]   operands, requester i on bits [4i+3:4i]
//   mul_a/mul_b [4]        registered operands to the multiplier
//   mul_start              registered start strobe to the multiplier
//   mul_result  [8]        product from the multiplier
//   mul_done               completion strobe, results in issue order
//   rsp_valid              response FIFO non-empty
//   rsp_ready              consumer takes the head response
//   rsp_id      [ID_W]     requester index of the head response (0 if empty)
//   rsp_data    [8]        product of the head response (0 if empty)
//   busy                   credit count nonzero
//   err                    sticky: completion arrived with no tag queued
// ---------------------------------------------------------------------------
module vedic_mul_arbiter #(
   parameter int NREQ  = 4,
   parameter int ID_W  = 2,
   parameter int DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [4*NREQ-1:0] req_a,
   input  logic [4*NREQ-1:0] req_b,
   output logic [3:0]        mul_a,
   output logic [3:0]        mul_b,
   output logic              mul_start,
   input  logic [7:0]        mul_result,
   input  logic              mul_done,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ID_W-1:0]   rsp_id,
   output logic [7:0]        rsp_data,
   output logic              busy,
   output logic              err
);

   // FIFO index width. Each pointer carries one extra wrap bit on top.
   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int RES_W = ID_W + 8;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
   localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NREQ - 1);
   localparam logic [AW-1:0]    IDX_LAST = AW'(DEPTH - 1);

   // Advance a {wrap, index} pointer. The index wraps explicitly, so DEPTH
   // does not have to be a power of two.
   function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
      logic [AW:0] n;
      if (p[AW-1:0] == IDX_LAST) begin
         n = {~p[AW], {AW{1'b0}}};
      end else begin
         n = {p[AW], p[AW-1:0] + AW'(1)};
      end
      return n;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_reg;
   logic [ID_W-1:0]  last_reg;
   logic             err_reg;
   logic             mul_start_reg;
   logic [3:0]       mul_a_reg;
   logic [3:0]       mul_b_reg;

   logic [ID_W-1:0]  tag_mem [DEPTH];
   logic [AW:0]      tag_wr_reg;
   logic [AW:0]      tag_rd_reg;

   logic [RES_W-1:0] res_mem [DEPTH];
   logic [AW:0]      res_wr_reg;
   logic [AW:0]      res_rd_reg;

   // ------------------------------------------------------------------
   // Per-requester operand views
   // ------------------------------------------------------------------
   logic [3:0] op_a [NREQ];
   logic [3:0] op_b [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign op_a[gi] = req_a[4*gi +: 4];
         assign op_b[gi] = req_b[4*gi +: 4];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Round-robin arbitration
   // The first pass covers indices above last_reg. The second pass wraps
   // around to indices at or below last_reg. Together they search from
   // last_reg+1 in circular order. The current credit count gates every
   // grant. A pop in this cycle therefore frees a credit only from the next
   // cycle onward. Grants are also held off while reset is asserted.
   // ------------------------------------------------------------------
   logic [NREQ-1:0] grant;
   logic            grant_any;
   logic [ID_W-1:0] grant_idx;
   logic [3:0]      sel_a;
   logic [3:0]      sel_b;
   logic            credit_ok;

   assign credit_ok = (cnt_reg < CNT_MAX);

   always_comb begin
      grant     = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      sel_a     = '0;
      sel_b     = '0;
      if (credit_ok && reset) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!grant_any && req_valid[i] && (ID_W'(i) > last_reg)) begin
               grant[i]  = 1'b1;
               grant_any = 1'b1;
               grant_idx = ID_W'(i);
               sel_a     = op_a[i];
               sel_b     = op_b[i];
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (!grant_any && req_valid[i] && (ID_W'(i) <= last_reg)) begin
               grant[i]  = 1'b1;
               grant_any = 1'b1;
               grant_idx = ID_W'(i);
               sel_a     = op_a[i];
               sel_b     = op_b[i];
            end
         end
      end
   end

   assign req_ready = grant;

   // A grant is only raised for a valid requester, so a grant means issue.
   logic issue;
   assign issue = grant_any;

   // ------------------------------------------------------------------
   // Tag FIFO: requester index of each in-flight operation
   // ------------------------------------------------------------------
   logic            tag_empty;
   logic            tag_pop;
   logic [ID_W-1:0] tag_head;

   assign tag_empty = (tag_wr_reg == tag_rd_reg);
   assign tag_pop   = mul_done && !tag_empty;
   assign tag_head  = tag_mem[tag_rd_reg[AW-1:0]];

   always_ff @(posedge clk) begin
      if (issue) begin
         tag_mem[tag_wr_reg[AW-1:0]] <= grant_idx;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_wr_reg <= '0;
         tag_rd_reg <= '0;
      end else begin
         if (issue) begin
            tag_wr_reg <= ptr_inc(tag_wr_reg);
         end
         if (tag_pop) begin
            tag_rd_reg <= ptr_inc(tag_rd_reg);
         end
      end
   end

   // ------------------------------------------------------------------
   // Result FIFO: {tag, product} in completion order
   // Credits already prevent an overflow. The full term only protects
   // against a push that is not matched by a pop in the same cycle.
   // ------------------------------------------------------------------
   logic             res_empty;
   logic             res_full;
   logic             res_push;
   logic             res_pop;
   logic [RES_W-1:0] res_head;

   assign res_empty = (res_wr_reg == res_rd_reg);
   assign res_full  = (res_wr_reg[AW-1:0] == res_rd_reg[AW-1:0]) &&
                      (res_wr_reg[AW] != res_rd_reg[AW]);
   assign res_pop   = !res_empty && rsp_ready;
   assign res_push  = tag_pop && (!res_full || res_pop);
   assign res_head  = res_mem[res_rd_reg[AW-1:0]];

   always_ff @(posedge clk) begin
      if (res_push) begin
         res_mem[res_wr_reg[AW-1:0]] <= {tag_head, mul_result};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         res_wr_reg <= '0;
         res_rd_reg <= '0;
      end else begin
         if (res_push) begin
            res_wr_reg <= ptr_inc(res_wr_reg);
         end
         if (res_pop) begin
            res_rd_reg <= ptr_inc(res_rd_reg);
         end
      end
   end

   // The head of an empty FIFO reads as zero. Stale memory contents never
   // reach the outputs.
   always_comb begin
      rsp_id   = '0;
      rsp_data = '0;
      if (!res_empty) begin
         rsp_id   = res_head[RES_W-1 -: ID_W];
         rsp_data = res_head[7:0];
      end
   end

   assign rsp_valid = !res_empty;

   // ------------------------------------------------------------------
   // Credits, round-robin pointer, issue registers, error flag
   // A spurious completion (tag FIFO empty) consumes no credit. The credit
   // is returned only when the response leaves the FIFO.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_reg <= '0;
      end else begin
         case ({issue, res_pop})
            2'b10:   cnt_reg <= cnt_reg + CNT_W'(1);
            2'b01:   cnt_reg <= cnt_reg - CNT_W'(1);
            default: cnt_reg <= cnt_reg;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_reg      <= LAST_RST;
         mul_start_reg <= 1'b0;
         mul_a_reg     <= '0;
         mul_b_reg     <= '0;
      end else begin
         mul_start_reg <= issue;
         if (issue) begin
            last_reg  <= grant_idx;
            mul_a_reg <= sel_a;
            mul_b_reg <= sel_b;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_reg <= 1'b0;
      end else if (mul_done && tag_empty) begin
         err_reg <= 1'b1;
      end
   end

   assign mul_start = mul_start_reg;
   assign mul_a     = mul_a_reg;
   assign mul_b     = mul_b_reg;
   assign busy      = (cnt_reg != '0);
   assign err       = err_reg;

endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vedic_mul_arbiter
// Drives vedic_mul_arbiter with directed and random traffic. A behavioural
// multiplier with a fixed latency sits on the mul_* ports. A queue-based
// reference model predicts grants, operands, responses and flags every cycle.
// ---------------------------------------------------------------------------
module tb_vedic_mul_arbiter;

   localparam int NREQ  = 4;
   localparam int ID_W  = 2;
   localparam int DEPTH = 8;
   localparam int LAT   = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [4*NREQ-1:0] req_a;
   logic [4*NREQ-1:0] req_b;
   logic [3:0]        mul_a;
   logic [3:0]        mul_b;
   logic              mul_start;
   logic [7:0]        mul_result;
   logic              mul_done;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [ID_W-1:0]   rsp_id;
   logic [7:0]        rsp_data;
   logic              busy;
   logic              err;

   always #5 clk = ~clk;

   vedic_mul_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_start  (mul_start),
      .mul_result (mul_result),
      .mul_done   (mul_done),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .busy       (busy),
      .err        (err)
   );

   // Behavioural pipelined multiplier. It shares the reset with the DUT.
   logic [LAT-1:0] pipe_v;
   logic [7:0]     pipe_p [LAT];
   logic           force_done;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         pipe_v <= '0;
         for (int s = 0; s < LAT; s++) pipe_p[s] <= '0;
      end else begin
         pipe_v    <= {pipe_v[LAT-2:0], mul_start};
         pipe_p[0] <= {4'b0, mul_a} * {4'b0, mul_b};
         for (int s = 1; s < LAT; s++) pipe_p[s] <= pipe_p[s-1];
      end
   end

   assign mul_done   = pipe_v[LAT-1] | force_done;
   assign mul_result = pipe_p[LAT-1];

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   typedef struct {
      int id;
      int prod;
   } op_t;

   op_t inflight_q[$];
   op_t result_q[$];
   int  m_last;
   int  m_err;
   int  m_start;
   int  m_a;
   int  m_b;

   int compared   = 0;
   int mismatched = 0;

   int dut_hs;
   int obs_grants[$];
   int rsp_cnt;
   int last_rsp_id;
   int last_rsp_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int last_i);
      int idx;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (last_i + k) % NREQ;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      inflight_q.delete();
      result_q.delete();
      m_last  = NREQ - 1;
      m_err   = 0;
      m_start = 0;
      m_a     = 0;
      m_b     = 0;
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_req_ready"}, req_ready, 0);
      check({pfx, "_mul_start"}, mul_start, 0);
      check({pfx, "_mul_a"},     mul_a,     0);
      check({pfx, "_mul_b"},     mul_b,     0);
      check({pfx, "_rsp_valid"}, rsp_valid, 0);
      check({pfx, "_rsp_id"},    rsp_id,    0);
      check({pfx, "_rsp_data"},  rsp_data,  0);
      check({pfx, "_busy"},      busy,      0);
      check({pfx, "_err"},       err,       0);
   endtask

   // One clock cycle. Entered 1 time unit after a rising edge, once inputs
   // are set. The task checks outputs late in the cycle, advances the model
   // at the edge and returns 1 time unit after it.
   task automatic step();
      int              pick;
      logic [NREQ-1:0] exp_ready;
      bit              do_issue;
      bit              do_pop;
      bit              done_s;
      int              ia;
      int              ib;
      #3;
      pick      = rr_pick(req_valid, m_last);
      exp_ready = '0;
      do_issue  = 0;
      if (pick >= 0 && (inflight_q.size() + result_q.size()) < DEPTH) begin
         exp_ready[pick] = 1'b1;
         do_issue        = 1;
      end
      check("req_ready", req_ready, exp_ready);
      check("rsp_valid", rsp_valid, result_q.size() != 0);
      check("rsp_id",    rsp_id,    result_q.size() != 0 ? result_q[0].id : 0);
      check("rsp_data",  rsp_data,  result_q.size() != 0 ? result_q[0].prod : 0);
      check("busy",      busy,      (inflight_q.size() + result_q.size()) != 0);
      check("err",       err,       m_err);
      check("mul_start", mul_start, m_start);
      check("mul_a",     mul_a,     m_a);
      check("mul_b",     mul_b,     m_b);

      if (|(req_ready & req_valid)) begin
         dut_hs++;
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) obs_grants.push_back(i);
      end
      do_pop = (result_q.size() != 0) && rsp_ready;
      if (rsp_valid && rsp_ready) begin
         rsp_cnt++;
         last_rsp_id   = rsp_id;
         last_rsp_data = rsp_data;
      end
      done_s = mul_done;
      ia = 0;
      ib = 0;
      if (do_issue) begin
         ia = req_a[4*pick +: 4];
         ib = req_b[4*pick +: 4];
      end

      @(posedge clk);
      if (do_pop) void'(result_q.pop_front());
      if (done_s) begin
         if (inflight_q.size() != 0) result_q.push_back(inflight_q.pop_front());
         else m_err = 1;
      end
      if (do_issue) begin
         inflight_q.push_back('{id: pick, prod: ia * ib});
         m_last  = pick;
         m_start = 1;
         m_a     = ia;
         m_b     = ib;
      end else begin
         m_start = 0;
      end
      #1;
   endtask

   task automatic rand_operands();
      req_a = 16'($urandom);
      req_b = 16'($urandom);
   endtask

   // ------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------
   int pc;
   int cyc;
   int hs0;

   initial begin
      reset      = 1'b1;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      rsp_ready  = 1'b0;
      force_done = 1'b0;
      dut_hs     = 0;
      rsp_cnt    = 0;
      model_reset();
      #1 reset = 1'b0;
      #2;
      check_reset_values("reset");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Single request from requester 2: 0xB * 0xD = 0x8F
      rsp_ready  = 1'b1;
      req_valid  = 4'b0100;
      req_a      = 16'h0B00;
      req_b      = 16'h0D00;
      rsp_cnt    = 0;
      step();
      req_valid  = '0;
      repeat (10) step();
      check("single_rsp_count", rsp_cnt, 1);
      check("single_rsp_id",    last_rsp_id, 2);
      check("single_rsp_data",  last_rsp_data, 8'h8F);
      check("single_busy",      busy, 0);
      check("single_err",       err, 0);

      // Round robin over all 256 operand pairs, one issue per cycle
      req_valid = '1;
      rsp_ready = 1'b1;
      hs0       = dut_hs;
      rsp_cnt   = 0;
      obs_grants.delete();
      pc        = 0;
      cyc       = 0;
      while ((dut_hs - hs0) < 256 && cyc < 400) begin
         for (int i = 0; i < NREQ; i++) begin
            req_a[4*i +: 4] = pc[7:4];
            req_b[4*i +: 4] = pc[3:0];
         end
         step();
         cyc++;
         pc = dut_hs - hs0;
      end
      check("rr_cycles", cyc, 256);
      // The previous grant went to requester 2, so the rotation starts at 3.
      for (int k = 0; k < 8; k++) check("rr_order", obs_grants[k], (k + 3) % NREQ);
      req_valid = '0;
      repeat (12) step();
      check("rr_rsp_count", rsp_cnt, 256);

      // Credit stall: no responses drained, so only DEPTH issues occur
      rsp_ready = 1'b0;
      req_valid = '1;
      hs0       = dut_hs;
      repeat (15) begin
         rand_operands();
         step();
      end
      check("stall_issues", dut_hs - hs0, DEPTH);
      check("stall_ready",  req_ready, 0);
      rsp_ready = 1'b1;
      hs0       = dut_hs;
      step();
      check("stall_same_cycle", dut_hs - hs0, 0);
      rsp_ready = 1'b0;
      step();
      check("stall_next_cycle", dut_hs - hs0, 1);

      // Random traffic with random back-pressure, starting from a full FIFO
      hs0 = dut_hs;
      cyc = 0;
      while ((dut_hs - hs0) < 20 && cyc < 500) begin
         req_valid = NREQ'($urandom);
         rsp_ready = 1'($urandom);
         rand_operands();
         step();
         cyc++;
      end
      check("random_issues", dut_hs - hs0, 20);
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (20) step();
      check("random_drained_busy",  busy, 0);
      check("random_drained_valid", rsp_valid, 0);

      // Spurious completion with nothing in flight
      force_done = 1'b1;
      step();
      force_done = 1'b0;
      check("spurious_err", err, 1);
      repeat (3) step();
      check("spurious_err_sticky", err, 1);
      check("spurious_rsp_valid",  rsp_valid, 0);

      // Reset in the middle of a burst with 5 operations outstanding
      rsp_ready = 1'b0;
      req_valid = '1;
      hs0       = dut_hs;
      cyc       = 0;
      while ((dut_hs - hs0) < 5 && cyc < 50) begin
         rand_operands();
         step();
         cyc++;
      end
      check("midreset_outstanding", dut_hs - hs0, 5);
      reset = 1'b0;
      #1;
      check_reset_values("midreset");
      model_reset();
      @(posedge clk);
      #1;
      req_valid = '0;
      reset     = 1'b1;

      // Fresh request after reset: requester 1, 7 * 9 = 0x3F
      rsp_ready = 1'b1;
      req_valid = 4'b0010;
      req_a     = 16'h0070;
      req_b     = 16'h0090;
      rsp_cnt   = 0;
      step();
      req_valid = '0;
      repeat (10) step();
      check("fresh_rsp_count", rsp_cnt, 1);
      check("fresh_rsp_id",    last_rsp_id, 1);
      check("fresh_rsp_data",  last_rsp_data, 8'h3F);
      check("fresh_err",       err, 0);
      check("fresh_busy",      busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
